// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
// Sequences a PLL from power-up through frequency acquisition, phase
// acquisition and lock. It also supervises the lock and reports a fault on
// timeout or on loss of lock.
//
// Ports:
//   clk_ref                    reference clock (only clock)
//   n_rst                      synchronous active-low reset
//   start / stop               acquisition request / shutdown request (stop wins)
//   n_cfg                      divide ratio, latched only when a start is accepted
//   kp_acq, ki_acq             loop gains used during settle and frequency acquisition
//   kp_trk, ki_trk             loop gains used during phase acquisition and lock
//   timeout_cyc                acquisition timeout in cycles, 0 disables it
//   freq_locked, phase_locked  lock flags from the PLL loop filter
//   pll_enable, n, kp, ki      registered controls to the PLL
//   freq_lock_range            lock-window select
//   busy, locked, fault        registered status flags
//   lock_lost                  one-cycle pulse when an established lock is lost
//   state                      current state encoding
//
// Build option:
//   PLL_LOCK_CTRL_RELOCK_EN    when defined, a loss of lock re-enters frequency
//                              acquisition instead of going to FAULT.

module pll_lock_ctrl #(
    parameter int N_SIZE     = 8,
    parameter int K_SIZE     = 16,
    parameter int TMO_SIZE   = 16,
    parameter int SETTLE_CYC = 32,
    parameter int LOCK_HOLD  = 8
) (
    input  logic                clk_ref,
    input  logic                n_rst,
    input  logic                start,
    input  logic                stop,
    input  logic [N_SIZE-1:0]   n_cfg,
    input  logic [K_SIZE-1:0]   kp_acq,
    input  logic [K_SIZE-1:0]   ki_acq,
    input  logic [K_SIZE-1:0]   kp_trk,
    input  logic [K_SIZE-1:0]   ki_trk,
    input  logic [TMO_SIZE-1:0] timeout_cyc,
    input  logic                freq_locked,
    input  logic                phase_locked,
    output logic                pll_enable,
    output logic [N_SIZE-1:0]   n,
    output logic [K_SIZE-1:0]   kp,
    output logic [K_SIZE-1:0]   ki,
    output logic [1:0]          freq_lock_range,
    output logic                busy,
    output logic                locked,
    output logic                fault,
    output logic                lock_lost,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_FREQ_ACQ  = 3'd2,
        ST_PHASE_ACQ = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam int HOLD_W   = $clog2(LOCK_HOLD + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(LOCK_HOLD - 1);

    state_t              cur_st, nxt_st;
    logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [TMO_SIZE-1:0] tmo_cnt, tmo_nxt, tmo_inc;
    logic                tmo_hit;
    logic                lost_nxt;
    logic                latch_n;

    // The timeout counter saturates at its maximum. Comparing with >= means a
    // timeout value lowered mid-acquisition still trips the fault on the next cycle.
    assign tmo_inc = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
    assign tmo_hit = (timeout_cyc != '0) && (tmo_cnt >= timeout_cyc - 1'b1);

    assign state = cur_st;

    // Next-state and counter update. A hold counter reaching HOLD_LAST on a
    // qualifying cycle completes the LOCK_HOLD-long run in that same cycle.
    always_comb begin
        nxt_st     = cur_st;
        settle_nxt = settle_cnt;
        hold_nxt   = hold_cnt;
        tmo_nxt    = tmo_cnt;
        lost_nxt   = 1'b0;
        latch_n    = 1'b0;
        if (stop) begin
            nxt_st     = ST_IDLE;
            settle_nxt = '0;
            hold_nxt   = '0;
            tmo_nxt    = '0;
        end else begin
            case (cur_st)
                ST_IDLE, ST_FAULT: begin
                    if (start) begin
                        nxt_st     = ST_SETTLE;
                        latch_n    = 1'b1;
                        settle_nxt = '0;
                        hold_nxt   = '0;
                        tmo_nxt    = '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt >= SETTLE_LAST) begin
                        nxt_st     = ST_FREQ_ACQ;
                        settle_nxt = '0;
                        hold_nxt   = '0;
                        tmo_nxt    = '0;
                    end else begin
                        settle_nxt = settle_cnt + 1'b1;
                    end
                end
                ST_FREQ_ACQ, ST_PHASE_ACQ: begin
                    if (tmo_hit) begin
                        nxt_st   = ST_FAULT;
                        hold_nxt = '0;
                        tmo_nxt  = '0;
                    end else begin
                        tmo_nxt = tmo_inc;
                        if ((cur_st == ST_FREQ_ACQ) ? freq_locked : phase_locked) begin
                            if (hold_cnt >= HOLD_LAST) begin
                                nxt_st   = (cur_st == ST_FREQ_ACQ) ? ST_PHASE_ACQ : ST_LOCKED;
                                hold_nxt = '0;
                            end else begin
                                hold_nxt = hold_cnt + 1'b1;
                            end
                        end else begin
                            hold_nxt = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // While locked, the hold counter counts consecutive cycles
                    // with freq_locked low.
                    if (!freq_locked) begin
                        if (hold_cnt >= HOLD_LAST) begin
                            lost_nxt = 1'b1;
                            hold_nxt = '0;
                            tmo_nxt  = '0;
`ifdef PLL_LOCK_CTRL_RELOCK_EN
                            nxt_st   = ST_FREQ_ACQ;
`else
                            nxt_st   = ST_FAULT;
`endif
                        end else begin
                            hold_nxt = hold_cnt + 1'b1;
                        end
                    end else begin
                        hold_nxt = '0;
                    end
                end
                default: begin
                    nxt_st     = ST_IDLE;
                    settle_nxt = '0;
                    hold_nxt   = '0;
                    tmo_nxt    = '0;
                end
            endcase
        end
    end

    // State register. The outputs are registered from the decoded next state,
    // so they are already correct in the first cycle of each new state.
    always_ff @(posedge clk_ref) begin
        if (!n_rst) begin
            cur_st          <= ST_IDLE;
            settle_cnt      <= '0;
            hold_cnt        <= '0;
            tmo_cnt         <= '0;
            pll_enable      <= 1'b0;
            n               <= '0;
            kp              <= '0;
            ki              <= '0;
            freq_lock_range <= 2'b00;
            busy            <= 1'b0;
            locked          <= 1'b0;
            fault           <= 1'b0;
            lock_lost       <= 1'b0;
        end else begin
            cur_st     <= nxt_st;
            settle_cnt <= settle_nxt;
            hold_cnt   <= hold_nxt;
            tmo_cnt    <= tmo_nxt;
            lock_lost  <= lost_nxt;
            if (latch_n) begin
                n <= n_cfg;
            end
            pll_enable <= (nxt_st != ST_IDLE) && (nxt_st != ST_FAULT);
            busy       <= (nxt_st != ST_IDLE) && (nxt_st != ST_FAULT);
            locked     <= (nxt_st == ST_LOCKED);
            fault      <= (nxt_st == ST_FAULT);
            case (nxt_st)
                ST_SETTLE, ST_FREQ_ACQ: begin
                    kp              <= kp_acq;
                    ki              <= ki_acq;
                    freq_lock_range <= 2'b11;
                end
                ST_PHASE_ACQ, ST_LOCKED: begin
                    kp              <= kp_trk;
                    ki              <= ki_trk;
                    freq_lock_range <= 2'b01;
                end
                default: begin
                    kp              <= '0;
                    ki              <= '0;
                    freq_lock_range <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameters: N_SIZE, default 8, divider ratio width; K_SIZE, default 16, kp/ki width (8 integer + 8 fraction bits); TMO_SIZE, default 16, timeout counter width; SETTLE_CYC, default 32, post-enable settle cycles; LOCK_HOLD, default 8, consecutive cycles needed to qualify or disqualify a lock.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_ref  in  1  reference clock, sole clock
- n_rst  in  1  synchronous active-low reset
- start  in  1  request acquisition
- stop  in  1  request shutdown
- n_cfg  in  N_SIZE  requested divide ratio
- kp_acq, ki_acq  in  K_SIZE  acquisition gains
- kp_trk, ki_trk  in  K_SIZE  tracking gains
- timeout_cyc  in  TMO_SIZE  acquisition timeout; 0 disables the timeout
- freq_locked, phase_locked  in  1  lock flags from the PLL filter
- pll_enable  out  1  PLL enable
- n  out  N_SIZE  divide ratio to the PLL
- kp, ki  out  K_SIZE  gains to the PLL
- freq_lock_range  out  2  lock-window select
- busy  out  1  high in any state except IDLE and FAULT
- locked  out  1  high in LOCKED
- fault  out  1  high in FAULT
- lock_lost  out  1  one-cycle pulse on loss of lock
- state  out  3  current state encoding

Function
REQ-003 SHALL implement the states IDLE=0, SETTLE=1, FREQ_ACQ=2, PHASE_ACQ=3, LOCKED=4 and FAULT=5, and drive all outputs from registers.
REQ-004 IDLE: pll_enable=0; on start, SHALL latch n_cfg into n and go to SETTLE on the next edge.
REQ-005 SETTLE: pll_enable=1, kp/ki=acq gains, freq_lock_range=2'b11; after exactly SETTLE_CYC cycles SHALL go to FREQ_ACQ.
REQ-006 FREQ_ACQ: freq_locked high for LOCK_HOLD consecutive cycles SHALL go to PHASE_ACQ; any low cycle clears the qualify count.
REQ-007 PHASE_ACQ: kp/ki=trk gains, freq_lock_range=2'b01; phase_locked high for LOCK_HOLD consecutive cycles SHALL go to LOCKED.
REQ-008 The timeout counter SHALL clear on entry to FREQ_ACQ and count through FREQ_ACQ and PHASE_ACQ; when it reaches timeout_cyc (nonzero), the block SHALL go to FAULT.
REQ-009 LOCKED: freq_locked low for LOCK_HOLD consecutive cycles is a loss of lock; lock_lost SHALL pulse for one cycle and the next state is set by REQ-015.
REQ-010 FAULT: pll_enable=0, fault=1; start SHALL restart at SETTLE with n_cfg relatched; stop SHALL go to IDLE.
REQ-011 stop in any state SHALL go to IDLE on the next edge with pll_enable=0; stop wins over a simultaneous start.
REQ-012 n_cfg changes outside a start acceptance SHALL be ignored; start outside IDLE/FAULT SHALL be ignored.
REQ-013 Counters SHALL saturate and never wrap; LOCK_HOLD=1 qualifies in a single cycle.

Reset
REQ-014 On n_rst=0 at the clk_ref edge: state=IDLE, pll_enable=0, n=0, kp=ki=0, freq_lock_range=2'b00, busy=locked=fault=lock_lost=0, all counters 0; this applies in any state, mid-acquisition included.

Configuration
REQ-015 With macro PLL_LOCK_CTRL_RELOCK_EN defined, loss of lock SHALL go to FREQ_ACQ with acq gains and the timeout counter cleared; without it, loss of lock SHALL go to FAULT.

Verification
REQ-016 Reset, start with n_cfg=20 -> n=20, 32 cycles in SETTLE, then FREQ_ACQ; freq_locked high 8 cycles -> PHASE_ACQ with trk gains; phase_locked high 8 cycles -> locked=1.
REQ-017 In FREQ_ACQ, freq_locked high 7 cycles, low 1 cycle, high 8 cycles -> PHASE_ACQ entered only after the second run.
REQ-018 timeout_cyc=100, lock flags held low -> fault=1 and pll_enable=0 exactly 100 cycles after FREQ_ACQ entry; timeout_cyc=0 -> never faults.
REQ-019 In LOCKED, freq_locked low 8 cycles -> lock_lost high for one cycle, then FREQ_ACQ (macro defined) or FAULT (macro undefined).
REQ-020 start and stop asserted together in PHASE_ACQ -> IDLE next cycle; n_rst low mid-SETTLE -> all outputs at reset values next edge.
